// File: rtl/sum_latch_uart_tx_p.sv
// Sum-latch UART transmitter: latches two operands, keeps their sum and sends it as LSB-first UART bytes.
// Optional macro SUMLATCH_UART_PARITY_EN adds an even-parity bit per byte (8E1 instead of 8N1).
module sum_latch_uart_tx_p #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              uart_tx_en,
  output logic              uart_txd,
  output logic              uart_tx_busy,
  output logic [DATA_W:0]   sum_out
);

  localparam int NBYTES = (DATA_W + 8) / 8;
  localparam int SH_W   = 8 * NBYTES;
  localparam int TMR_W  = $clog2(CLK_DIV);
  localparam int CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SUMLATCH_UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic parity8(input logic [7:0] b);
    parity8 = ^b;
  endfunction

  // Pin order in the synchroniser vectors: {tx_en, save_b_n, save_a_n}
  logic [2:0] sync1_q, sync2_q, hist_q;
  logic       a_fall_s, b_fall_s, tx_rise_s;

  logic [DATA_W-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic [DATA_W:0]   sum_q, sum_d;

  state_e           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [SH_W-1:0]  shift_q;
  logic             txd_q, busy_q;
`ifdef SUMLATCH_UART_PARITY_EN
  logic             par_q;
`endif
  logic             bit_end_s;

  // Two-stage synchroniser plus history stage, reset to the idle pin levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 3'b011;
      sync2_q <= 3'b011;
      hist_q  <= 3'b011;
    end else begin
      sync1_q <= {uart_tx_en, save_b_n, save_a_n};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign a_fall_s  = ~sync2_q[0] & hist_q[0];
  assign b_fall_s  = ~sync2_q[1] & hist_q[1];
  assign tx_rise_s = sync2_q[2] & ~hist_q[2];
  assign bit_end_s = (tmr_q == TMR_W'(CLK_DIV - 1));

  // Operand capture and next sum, carry kept in the extra MSB
  always_comb begin
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    if (a_fall_s) begin
      reg_a_d = data_input;
    end else begin
      reg_a_d = reg_a_q;
    end
    if (b_fall_s) begin
      reg_b_d = data_input;
    end else begin
      reg_b_d = reg_b_q;
    end
    sum_d = {1'b0, reg_a_q} + {1'b0, reg_b_q};
  end

  // Operand and sum registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
      sum_q   <= '0;
    end else begin
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      sum_q   <= sum_d;
    end
  end

  // Transmit FSM; txd and busy change on the same edge as the state so both stay registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef SUMLATCH_UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          tmr_q  <= '0;
          if (tx_rise_s) begin
            shift_q    <= SH_W'(sum_q);
            byte_cnt_q <= '0;
            state_q    <= ST_START;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= ST_DATA;
`ifdef SUMLATCH_UART_PARITY_EN
            par_q     <= parity8(shift_q[7:0]);
`endif
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            tmr_q   <= '0;
            // Shifting after every bit leaves the next byte aligned at bit 0
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == 3'd7) begin
`ifdef SUMLATCH_UART_PARITY_EN
              txd_q   <= par_q;
              state_q <= ST_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
`ifdef SUMLATCH_UART_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            tmr_q   <= '0;
            txd_q   <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end_s) begin
            tmr_q <= '0;
            if (byte_cnt_q < CNT_W'(NBYTES - 1)) begin
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
              txd_q      <= 1'b0;
              state_q    <= ST_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          tmr_q   <= '0;
        end
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign sum_out      = sum_q;

endmodule

// File: tb/tb_sum_latch_uart_tx_p.sv
// Randomised self-checking bench for sum_latch_uart_tx_p (DATA_W=8, CLK_DIV=4, default 8N1 build).
// Expected bytes come from plain arithmetic on the operands; the line is decoded by mid-bit sampling.
module tb_sum_latch_uart_tx_p;

  localparam int DW    = 8;
  localparam int CD    = 4;
  localparam int NB    = 2;
  localparam int BITP  = 10 * CD;
  localparam int FRAME = NB * BITP;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          save_a_n;
  logic          save_b_n;
  logic [DW-1:0] data_input;
  logic          uart_tx_en;
  logic          uart_txd;
  logic          uart_tx_busy;
  logic [DW:0]   sum_out;

  int errors = 0;
  int checks = 0;

  logic        line_r [0:127];
  logic        busy_r [0:127];
  logic [DW:0] sum_r  [0:127];
  int          lat_r;

  sum_latch_uart_tx_p #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .save_a_n     (save_a_n),
    .save_b_n     (save_b_n),
    .data_input   (data_input),
    .uart_tx_en   (uart_tx_en),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .sum_out      (sum_out)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_ops(input logic [DW-1:0] a, input logic [DW-1:0] b);
    data_input = a;
    save_a_n   = 1'b0;
    wait_clk(4);
    save_a_n = 1'b1;
    wait_clk(4);
    data_input = b;
    save_b_n   = 1'b0;
    wait_clk(4);
    save_b_n = 1'b1;
    wait_clk(4);
  endtask

  // Raises tx_en, waits for the start bit, then records 128 post-edge samples.
  // mode 1: second tx_en pulse plus an A capture mid-frame; mode 2: reset during byte 1 data bits.
  task automatic record_frame(input int hold, input int mode);
    lat_r      = 0;
    uart_tx_en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (uart_txd === 1'b0) begin
        lat_r = c;
        break;
      end
    end
    checks++;
    if (lat_r !== 3) begin
      errors++;
      $display("FAIL start_latency got %0d edges, expected 3", lat_r);
    end
    line_r[0] = uart_txd;
    busy_r[0] = uart_tx_busy;
    sum_r[0]  = sum_out;
    for (int i = 1; i < 128; i++) begin
      @(posedge clk);
      #1;
      line_r[i] = uart_txd;
      busy_r[i] = uart_tx_busy;
      sum_r[i]  = sum_out;
      if (i == hold) uart_tx_en = 1'b0;
      if (mode == 1) begin
        case (i)
          10: uart_tx_en = 1'b1;
          12: begin data_input = 8'h05; save_a_n = 1'b0; end
          14: uart_tx_en = 1'b0;
          20: save_a_n = 1'b1;
          default: ;
        endcase
      end
      if (mode == 2 && i == 50) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || sum_out !== 9'h000) begin
          errors++;
          $display("FAIL async_reset_midframe txd=%b busy=%b sum=%h expected txd=1 busy=0 sum=000",
                   uart_txd, uart_tx_busy, sum_out);
        end
      end
      if (mode == 2 && i == 53) reset_n = 1'b1;
    end
  endtask

  task automatic check_frame(input logic [DW:0] exp_sum, input string name);
    logic [8*NB-1:0] ext;
    logic [7:0]      got, expb;
    int              blen;
    bit              idle_ok;
    ext = (8*NB)'(exp_sum);
    for (int b = 0; b < NB; b++) begin
      expb = ext[b*8 +: 8];
      for (int j = 0; j < 8; j++) got[j] = line_r[b*BITP + (j+1)*CD + CD/2];
      checks++;
      if (got !== expb) begin
        errors++;
        $display("FAIL %s byte%0d got %h expected %h", name, b, got, expb);
      end
      checks++;
      if (line_r[b*BITP + CD/2] !== 1'b0 || line_r[b*BITP + 9*CD + CD/2] !== 1'b1) begin
        errors++;
        $display("FAIL %s framing%0d start=%b stop=%b expected start=0 stop=1", name, b,
                 line_r[b*BITP + CD/2], line_r[b*BITP + 9*CD + CD/2]);
      end
    end
    blen = 0;
    while (blen < 128 && busy_r[blen] === 1'b1) blen++;
    checks++;
    if (blen !== FRAME) begin
      errors++;
      $display("FAIL %s busy_len got %0d expected %0d", name, blen, FRAME);
    end
    idle_ok = 1'b1;
    for (int i = FRAME; i < 128; i++) begin
      if (line_r[i] !== 1'b1 || busy_r[i] !== 1'b0) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL %s post_frame_idle got activity expected txd=1 busy=0", name);
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset_n    = 1'b0;
    save_a_n   = 1'b1;
    save_b_n   = 1'b1;
    uart_tx_en = 1'b0;
    data_input = '0;
    wait_clk(3);
    checks++;
    if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || sum_out !== 9'h000) begin
      errors++;
      $display("FAIL reset_values txd=%b busy=%b sum=%h expected 1 0 000", uart_txd, uart_tx_busy, sum_out);
    end
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_clk(1);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_after_reset got line activity expected txd=1 busy=0");
    end
  endtask

  task automatic test_sum_frame(input logic [DW-1:0] a, input logic [DW-1:0] b, input string name);
    logic [DW:0] exp_sum;
    exp_sum = {1'b0, a} + {1'b0, b};
    load_ops(a, b);
    checks++;
    if (sum_out !== exp_sum) begin
      errors++;
      $display("FAIL %s sum_out got %h expected %h", name, sum_out, exp_sum);
    end
    record_frame(2, 0);
    check_frame(exp_sum, name);
  endtask

  task automatic test_ignore_and_capture();
    load_ops(8'h20, 8'h30);
    record_frame(2, 1);
    check_frame(9'h050, "midframe");
    checks++;
    if (sum_r[15] !== 9'h050 || sum_r[16] !== 9'h035) begin
      errors++;
      $display("FAIL capture_timing got %h,%h expected 050,035", sum_r[15], sum_r[16]);
    end
    wait_clk(4);
    record_frame(2, 0);
    check_frame(9'h035, "after_midframe");
  endtask

  task automatic test_reset_midframe();
    load_ops(8'h9A, 8'h77);
    record_frame(2, 2);
    wait_clk(4);
    record_frame(2, 0);
    check_frame(9'h000, "after_reset");
  endtask

  task automatic test_hold_high();
    bit ok;
    logic [DW-1:0] a, b;
    a = DW'($urandom_range(0, 255));
    b = DW'($urandom_range(0, 255));
    load_ops(a, b);
    record_frame(1000, 0);
    check_frame({1'b0, a} + {1'b0, b}, "hold_high");
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wait_clk(1);
      if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_high_single got extra transmission expected none");
    end
    uart_tx_en = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      test_sum_frame(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_sum_frame(8'h12, 8'h34, "basic");
    test_sum_frame(8'hFF, 8'h01, "carry");
    test_ignore_and_capture();
    test_reset_midframe();
    test_hold_high();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
